// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state enums.
package alu_seq_pkg;

  localparam int unsigned OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_NEG_A = 3'd0,
    OP_NEG_B = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_AND   = 3'd4,
    OP_OR    = 3'd5,
    OP_MUL   = 3'd6,
    OP_XOR   = 3'd7
  } alu_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between producer, alu_seq and consumer.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
) ();
  import alu_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  alu_op_t          in_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_f;
  logic [WIDTH-1:0] out_hi;
  logic             out_zero;
  logic             out_neg;
  logic             out_carry;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_f, out_hi, out_zero, out_neg, out_carry, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_f, out_hi, out_zero, out_neg, out_carry, out_ovf
  );
endinterface

// File: rtl/alu_seq_mul.sv
// Unsigned WIDTH x WIDTH multiplier with full 2*WIDTH product.
// ALU_SEQ_FASTMUL_EN selects a combinational array; default is iterative shift-add.
module alu_seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;

`ifdef ALU_SEQ_FASTMUL_EN

  assign product = PW'(a) * PW'(b);
  assign done    = start;
  assign busy    = 1'b0;

`else

  localparam int unsigned    CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [PW-1:0]    mcand_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    acc_d;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // Product is the accumulator after the current partial product, so the
  // final sum is available combinationally in the last iteration.
  assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = busy_q && (cnt_q == LAST);
  assign busy    = busy_q;
  assign product = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= PW'(a);
      acc_q    <= '0;
      mplier_q <= b;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (done) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

`endif

endmodule

// File: rtl/alu_seq.sv
// Sequential handshaked ALU: eight ops, registered result and flags.
// Build option ALU_SEQ_FASTMUL_EN makes MUL single-cycle.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  if (WIDTH < 2) begin : g_width_chk
    $error("alu_seq: WIDTH must be >= 2");
  end

  localparam int unsigned      PW       = 2 * WIDTH;
  localparam int unsigned      MSB      = WIDTH - 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  alu_state_t state_q, state_d;

  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [PW-1:0]    mul_prod;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_f;
  logic             alu_c;
  logic             alu_v;

  logic             load;
  logic [WIDTH-1:0] res_f;
  logic [WIDTH-1:0] res_hi;
  logic             res_c;
  logic             res_v;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_f_q;
  logic [WIDTH-1:0] out_hi_q;
  logic             zero_q, neg_q, carry_q, ovf_q;

  assign bus.in_ready = (state_q == S_IDLE) && !mul_busy && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign mul_start    = accept && (bus.in_op == OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.in_a),
    .b       (bus.in_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle operations, evaluated directly on the presented operands.
  always_comb begin
    sum   = '0;
    alu_f = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.in_op)
      OP_NEG_A: begin
        alu_f = ~bus.in_a + WIDTH'(1);
        alu_v = (bus.in_a == MOST_NEG);
      end
      OP_NEG_B: begin
        alu_f = ~bus.in_b + WIDTH'(1);
        alu_v = (bus.in_b == MOST_NEG);
      end
      OP_ADD: begin
        sum   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        alu_f = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (bus.in_a[MSB] == bus.in_b[MSB]) && (alu_f[MSB] != bus.in_a[MSB]);
      end
      OP_SUB: begin
        sum   = {1'b0, bus.in_a} + {1'b0, ~bus.in_b} + (WIDTH+1)'(1);
        alu_f = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (bus.in_a[MSB] != bus.in_b[MSB]) && (alu_f[MSB] != bus.in_a[MSB]);
      end
      OP_AND:  alu_f = bus.in_a & bus.in_b;
      OP_OR:   alu_f = bus.in_a | bus.in_b;
      OP_XOR:  alu_f = bus.in_a ^ bus.in_b;
      OP_MUL:  alu_f = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and result selection; load marks a new result to register.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    res_f   = alu_f;
    res_hi  = '0;
    res_c   = alu_c;
    res_v   = alu_v;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.in_op == OP_MUL) begin
`ifdef ALU_SEQ_FASTMUL_EN
            load   = mul_done;
            res_f  = mul_prod[WIDTH-1:0];
            res_hi = mul_prod[PW-1:WIDTH];
            res_c  = |mul_prod[PW-1:WIDTH];
            res_v  = 1'b0;
`else
            state_d = S_MUL;
`endif
          end else begin
            load = 1'b1;
          end
        end
      end
      S_MUL: begin
        res_f  = mul_prod[WIDTH-1:0];
        res_hi = mul_prod[PW-1:WIDTH];
        res_c  = |mul_prod[PW-1:WIDTH];
        res_v  = 1'b0;
        if (mul_done) begin
          load    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
      out_hi_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_f_q     <= res_f;
      out_hi_q    <= res_hi;
      zero_q      <= (res_f == '0);
      neg_q       <= res_f[MSB];
      carry_q     <= res_c;
      ovf_q       <= res_v;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_f     = out_f_q;
  assign bus.out_hi    = out_hi_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_neg   = neg_q;
  assign bus.out_carry = carry_q;
  assign bus.out_ovf   = ovf_q;

endmodule
